// File: rtl/stream_mux_rr_pkg.sv
// Shared stream-block constants: arbitration mode encodings, channel-count limits,
// and the modulo-wrap helper used by the rotating search.
package stream_mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

  // Operands never exceed 2*n-2, so a single subtract is enough for the wrap.
  function automatic int rr_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N producer channels in, one registered stream out.
interface stream_mux_rr_if #(
  parameter int Bit_Width = 32,
  parameter int NUM_IN    = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*Bit_Width-1:0] in_data;
  logic [NUM_IN-1:0]           in_valid;
  logic [NUM_IN-1:0]           in_ready;
  logic                        mode;
  logic [SEL_W-1:0]            sel;
  logic [Bit_Width-1:0]        out_data;
  logic [SEL_W-1:0]            out_src;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: first requester at or after ptr wins.
// The pointer register is owned by the caller.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [SW-1:0] hit_idx;
  logic          hit;

  // Scan from the far end back toward ptr so the nearest requester is written last.
  always_comb begin
    logic [SW-1:0] ix;
    ix      = '0;
    hit_idx = '0;
    hit     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      ix = SW'(rr_wrap(int'(ptr) + k, N));
      if (req[ix]) begin
        hit_idx = ix;
        hit     = 1'b1;
      end
    end
  end

  assign grant_idx   = hit_idx;
  assign grant_valid = hit & en;

  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++)
      grant[i] = grant_valid & (hit_idx == SW'(i));
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// and a single registered output stage that reloads in the same cycle it drains.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int Bit_Width = 32,
  parameter  int NUM_IN    = 4,
  localparam int SEL_W     = $clog2(NUM_IN)
) (
  input  logic            gclk,
  input  logic            grst_n,
  stream_mux_rr_if.slave  s
);

  logic                 load;
  logic [NUM_IN-1:0]    sel_hot;
  logic [NUM_IN-1:0]    req;
  logic [NUM_IN-1:0]    grant;
  logic [SEL_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [SEL_W-1:0]     rr_ptr;
  logic [Bit_Width-1:0] sel_data;
  logic [Bit_Width-1:0] data_q;
  logic [SEL_W-1:0]     src_q;
  logic                 vld_q;

  assign load = ~vld_q | s.out_ready;

  // An out-of-range sel matches no bit, so it can never grant.
  always_comb begin
    sel_hot = '0;
    for (int i = 0; i < NUM_IN; i++)
      sel_hot[i] = (s.sel == SEL_W'(i));
  end

  // Fixed mode presents a single candidate, so the rotating search lands on it directly.
  assign req = (s.mode == MODE_RR) ? s.in_valid : (s.in_valid & sel_hot);

  rr_arbiter #(.N(NUM_IN)) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .en          (load),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign s.in_ready = grant;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (grant[i]) sel_data = s.in_data[i*Bit_Width +: Bit_Width];
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      data_q <= '0;
      src_q  <= '0;
      vld_q  <= 1'b0;
      rr_ptr <= '0;
    end else if (grant_valid) begin
      data_q <= sel_data;
      src_q  <= grant_idx;
      vld_q  <= 1'b1;
      if (s.mode == MODE_RR)
        rr_ptr <= (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
    end else if (s.out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign s.out_data  = data_q;
  assign s.out_src   = src_q;
  assign s.out_valid = vld_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: vector table for steady-state behaviour,
// hand sequences for reset, backpressure and asynchronous reset mid-stream.
module tb_stream_mux_rr;

  localparam int W = 32;
  localparam int N = 4;

  logic gclk = 1'b0;
  logic grst_n;
  int   npass = 0;
  int   ntotal = 0;

  always #5 gclk = ~gclk;

  stream_mux_rr_if #(.Bit_Width(W), .NUM_IN(N)) bus ();

  stream_mux_rr #(.Bit_Width(W), .NUM_IN(N)) dut (
    .gclk   (gclk),
    .grst_n (grst_n),
    .s      (bus)
  );

  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] iv;
    logic       ordy;
    logic [3:0] ex_rdy;
    logic       ex_vld;
    logic [1:0] ex_src;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] chan_word(input logic [1:0] i);
    return 32'hA5A5_0000 + {30'd0, i};
  endfunction

  task automatic drive(input logic m, input logic [1:0] sl, input logic [3:0] iv, input logic ordy);
    bus.mode      = m;
    bus.sel       = sl;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
  endtask

  task automatic chk_out(input string nm, input logic v, input logic [1:0] src);
    chk({nm, ".out_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
    chk({nm, ".out_src"},   {30'd0, bus.out_src},   {30'd0, src});
    chk({nm, ".out_data"},  bus.out_data,           chan_word(src));
  endtask

  initial begin
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = chan_word(2'(i));

    //            mode  sel   in_valid ordy  in_ready  vld   src
    vecs[0]  = '{1'b0, 2'd2, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 2'd1, 4'b0101, 1'b1, 4'b0000, 1'b0, 2'd2};
    vecs[2]  = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
    vecs[3]  = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3};
    vecs[4]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[5]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[9]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[10] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[11] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[12] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};

    // Reset with every channel requesting and the consumer stalled.
    grst_n = 1'b0;
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    repeat (2) @(posedge gclk);
    #1;
    chk("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.out_data",  bus.out_data,           32'd0);
    chk("rst.out_src",   {30'd0, bus.out_src},   32'd0);
    #2 grst_n = 1'b1;
    #1;
    chk("rst.ready_onehot", $countones(bus.in_ready), 32'd1);
    bus.in_valid = 4'b0000;
    @(posedge gclk); #1;

    for (int r = 0; r < 14; r++) begin
      drive(vecs[r].mode, vecs[r].sel, vecs[r].iv, vecs[r].ordy);
      #1;
      chk($sformatf("vec%0d.in_ready", r), {28'd0, bus.in_ready}, {28'd0, vecs[r].ex_rdy});
      @(posedge gclk); #1;
      chk_out($sformatf("vec%0d", r), vecs[r].ex_vld, vecs[r].ex_src);
    end

    // Stall with a full register: nothing granted, state frozen.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 2'd0, 4'b1111, 1'b0);
      #1;
      chk($sformatf("bp%0d.in_ready", c), {28'd0, bus.in_ready}, 32'd0);
      @(posedge gclk); #1;
      chk_out($sformatf("bp%0d", c), 1'b1, 2'd1);
    end

    // Release: held word drains and channel 2 loads on the same edge.
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel.in_ready", {28'd0, bus.in_ready}, 32'b0100);
    @(posedge gclk); #1;
    chk_out("bp_rel", 1'b1, 2'd2);

    // Asynchronous reset between edges while holding a word.
    bus.out_ready = 1'b0;
    #2 grst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst.out_src",   {30'd0, bus.out_src},   32'd0);
    chk("arst.out_data",  bus.out_data,           32'd0);
    #2 grst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_rel.in_ready", {28'd0, bus.in_ready}, 32'b0001);
    @(posedge gclk); #1;
    chk_out("arst_rel0", 1'b1, 2'd0);
    chk("arst_rel1.in_ready", {28'd0, bus.in_ready}, 32'b0010);
    @(posedge gclk); #1;
    chk_out("arst_rel1", 1'b1, 2'd1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
